// File: rtl/riscv_div_pkg.sv
// Shared definitions for the RV32M divide/remainder unit.
//   op encodings : OP_DIV, OP_DIVU, OP_REM, OP_REMU
//   state_e      : IDLE / CALC / DONE control states of riscv_divider
// Encoding note: op[1] selects remainder, op[0] selects unsigned.
package riscv_div_pkg;

  localparam logic [1:0] OP_DIV  = 2'b00;
  localparam logic [1:0] OP_DIVU = 2'b01;
  localparam logic [1:0] OP_REM  = 2'b10;
  localparam logic [1:0] OP_REMU = 2'b11;

  typedef enum logic [1:0] {
    IDLE = 2'b00,
    CALC = 2'b01,
    DONE = 2'b10
  } state_e;

endpackage

// File: rtl/div_unsigned_core.sv
// Unsigned iterative restoring divider datapath plus iteration counter.
// Ports:
//   clk, reset   : clock, synchronous active-high reset (clears counter)
//   load         : capture dividend/divisor, clear remainder and counter
//   step         : perform one restoring step
//   dividend     : unsigned dividend magnitude
//   divisor      : unsigned divisor magnitude
//   quo_next     : quotient after the step being performed this cycle
//   rem_next     : remainder after the step being performed this cycle
//   last         : the step performed this cycle is the WIDTH-th one
// quo_next/rem_next are combinational so the owner can register the final
// result on the same edge as the last step.
module div_unsigned_core #(
  parameter int WIDTH = 32
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             load,
  input  logic             step,
  input  logic [WIDTH-1:0] dividend,
  input  logic [WIDTH-1:0] divisor,
  output logic [WIDTH-1:0] quo_next,
  output logic [WIDTH-1:0] rem_next,
  output logic             last
);

  localparam int CW = $clog2(WIDTH) + 1;

  logic [WIDTH:0]   rem_q;
  logic [WIDTH-1:0] quo_q;   // dividend bits shift out the top, quotient bits in at the bottom
  logic [WIDTH-1:0] dvs_q;
  logic [CW-1:0]    cnt_q;

  logic [WIDTH:0]   rem_shift;
  logic [WIDTH:0]   rem_nxt;
  logic             take;

  always_comb begin
    rem_shift = {rem_q[WIDTH-1:0], quo_q[WIDTH-1]};
    take      = (rem_shift >= {1'b0, dvs_q});
    rem_nxt   = take ? (rem_shift - {1'b0, dvs_q}) : rem_shift;
    quo_next  = {quo_q[WIDTH-2:0], take};
    rem_next  = rem_nxt[WIDTH-1:0];   // remainder < divisor, so the top bit is always 0 here
    last      = (cnt_q == CW'(WIDTH - 1));
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      rem_q <= '0;
      quo_q <= '0;
      dvs_q <= '0;
      cnt_q <= '0;
    end else if (load) begin
      rem_q <= '0;
      quo_q <= dividend;
      dvs_q <= divisor;
      cnt_q <= '0;
    end else if (step) begin
      rem_q <= rem_nxt;
      quo_q <= quo_next;
      cnt_q <= cnt_q + CW'(1);
    end
  end

endmodule

// File: rtl/riscv_divider.sv
// Multi-cycle RV32M DIV/DIVU/REM/REMU unit with start/busy/done handshake.
// Ports:
//   clk, reset     : clock, synchronous active-high reset
//   start          : request an operation (only looked at in IDLE)
//   op             : 00 DIV, 01 DIVU, 10 REM, 11 REMU
//   DATA_A, DATA_B : dividend, divisor (captured on the accepting edge)
//   OUT, Zero      : registered result and result==0 flag, updated in DONE
//   busy           : high while iterating (CALC)
//   done           : one-cycle pulse, OUT/Zero valid
//   dbg_state      : current control state
// Handshake: start is accepted on a clock edge in IDLE; done pulses for one
// cycle when OUT/Zero are valid; start outside IDLE is ignored.
// Optional macro RISCV_DIV_EARLY_OUT_EN: divide-by-zero and signed overflow
// skip the iterations and complete straight from IDLE.
module riscv_divider
  import riscv_div_pkg::*;
#(
  parameter int WIDTH = 32
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             start,
  input  logic [1:0]       op,
  input  logic [WIDTH-1:0] DATA_A,
  input  logic [WIDTH-1:0] DATA_B,
  output logic [WIDTH-1:0] OUT,
  output logic             Zero,
  output logic             busy,
  output logic             done,
  output state_e           dbg_state
);

  localparam logic [WIDTH-1:0] MIN_VAL = {1'b1, {(WIDTH-1){1'b0}}};

  state_e           state;
  logic             is_rem_q;
  logic             div0_q;
  logic             ovf_q;
  logic             q_neg_q;
  logic             r_neg_q;
  logic [WIDTH-1:0] a_q;

  logic             in_signed;
  logic             a_neg, b_neg;
  logic [WIDTH-1:0] a_mag, b_mag;
  logic             in_div0, in_ovf;
  logic             accept;
  logic [WIDTH-1:0] quo_next, rem_next;
  logic             last;
  logic [WIDTH-1:0] calc_res;

  // Final result selection: special cases override the iterated values.
  function automatic logic [WIDTH-1:0] pick_result(
    input logic             is_rem,
    input logic [WIDTH-1:0] a,
    input logic             div0,
    input logic             ovf,
    input logic             q_neg,
    input logic             r_neg,
    input logic [WIDTH-1:0] quo,
    input logic [WIDTH-1:0] rem
  );
    logic [WIDTH-1:0] r;
    if (div0)       r = is_rem ? a : '1;
    else if (ovf)   r = is_rem ? '0 : MIN_VAL;
    else if (is_rem) r = r_neg ? (~rem + WIDTH'(1)) : rem;
    else            r = q_neg ? (~quo + WIDTH'(1)) : quo;
    return r;
  endfunction

  always_comb begin
    in_signed = ~op[0];
    a_neg     = in_signed & DATA_A[WIDTH-1];
    b_neg     = in_signed & DATA_B[WIDTH-1];
    a_mag     = a_neg ? (~DATA_A + WIDTH'(1)) : DATA_A;
    b_mag     = b_neg ? (~DATA_B + WIDTH'(1)) : DATA_B;
    in_div0   = (DATA_B == '0);
    in_ovf    = in_signed & (DATA_A == MIN_VAL) & (DATA_B == '1);
    accept    = (state == IDLE) & start;
    calc_res  = pick_result(is_rem_q, a_q, div0_q, ovf_q, q_neg_q, r_neg_q,
                            quo_next, rem_next);
  end

  div_unsigned_core #(.WIDTH(WIDTH)) u_core (
    .clk      (clk),
    .reset    (reset),
    .load     (accept),
    .step     (state == CALC),
    .dividend (a_mag),
    .divisor  (b_mag),
    .quo_next (quo_next),
    .rem_next (rem_next),
    .last     (last)
  );

  always_ff @(posedge clk) begin
    if (reset) begin
      state    <= IDLE;
      OUT      <= '0;
      Zero     <= 1'b0;
      busy     <= 1'b0;
      done     <= 1'b0;
      is_rem_q <= 1'b0;
      div0_q   <= 1'b0;
      ovf_q    <= 1'b0;
      q_neg_q  <= 1'b0;
      r_neg_q  <= 1'b0;
      a_q      <= '0;
    end else begin
      case (state)
        IDLE: begin
          done <= 1'b0;
          if (start) begin
            is_rem_q <= op[1];
            div0_q   <= in_div0;
            ovf_q    <= in_ovf;
            q_neg_q  <= (a_neg ^ b_neg) & ~in_div0;
            r_neg_q  <= a_neg;
            a_q      <= DATA_A;
`ifdef RISCV_DIV_EARLY_OUT_EN
            if (in_div0 | in_ovf) begin
              OUT   <= pick_result(op[1], DATA_A, in_div0, in_ovf, 1'b0, 1'b0, '0, '0);
              Zero  <= (pick_result(op[1], DATA_A, in_div0, in_ovf, 1'b0, 1'b0, '0, '0) == '0);
              done  <= 1'b1;
              state <= DONE;
            end else begin
              busy  <= 1'b1;
              state <= CALC;
            end
`else
            busy  <= 1'b1;
            state <= CALC;
`endif
          end
        end
        CALC: begin
          if (last) begin
            OUT   <= calc_res;
            Zero  <= (calc_res == '0);
            done  <= 1'b1;
            busy  <= 1'b0;
            state <= DONE;
          end
        end
        DONE: begin
          done  <= 1'b0;
          state <= IDLE;
        end
        default: begin
          busy  <= 1'b0;
          done  <= 1'b0;
          state <= IDLE;
        end
      endcase
    end
  end

  assign dbg_state = state;

endmodule

// File: tb/tb_riscv_divider.sv
// Directed testbench for riscv_divider (WIDTH=32).
module tb_riscv_divider;
  import riscv_div_pkg::*;

  localparam int W = 32;
`ifdef RISCV_DIV_EARLY_OUT_EN
  localparam int SPECIAL_LAT = 0;
`else
  localparam int SPECIAL_LAT = 32;
`endif

  logic         clk = 1'b0;
  logic         reset;
  logic         start;
  logic [1:0]   op;
  logic [W-1:0] data_a, data_b;
  logic [W-1:0] out;
  logic         zero, busy, done;
  state_e       dbg_state;

  int tests = 0;
  int fails = 0;

  riscv_divider #(.WIDTH(W)) dut (
    .clk       (clk),
    .reset     (reset),
    .start     (start),
    .op        (op),
    .DATA_A    (data_a),
    .DATA_B    (data_b),
    .OUT       (out),
    .Zero      (zero),
    .busy      (busy),
    .done      (done),
    .dbg_state (dbg_state)
  );

  // clock
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    tests++;
    assert (got === exp) else begin
      fails++;
      $error("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  // Issue one operation, scramble the inputs during CALC, optionally pulse
  // start while busy, then check latency, busy, OUT hold, result, Zero, pulse width.
  task automatic run_op(input string tag, input logic [1:0] o, input logic [W-1:0] a,
                        input logic [W-1:0] b, input int exp_lat,
                        input logic [W-1:0] exp_out, input logic exp_zero,
                        input bit pulse_start);
    int lat;
    bit busy_ok, hold_ok;
    logic [W-1:0] prev_out;
    @(negedge clk);
    start = 1'b1; op = o; data_a = a; data_b = b;
    prev_out = out;
    @(posedge clk); #1;
    start = 1'b0;
    op = 2'($urandom_range(0, 3));
    data_a = $urandom; data_b = $urandom;
    lat = 0; busy_ok = 1'b1; hold_ok = 1'b1;
    while (!done && lat < 100) begin
      if (busy !== 1'b1) busy_ok = 1'b0;
      if (out !== prev_out) hold_ok = 1'b0;
      start = pulse_start && (lat >= 3) && (lat <= 6);
      @(posedge clk); #1;
      lat++;
    end
    start = 1'b0;
    check({tag, " latency"}, 64'(lat), 64'(exp_lat));
    check({tag, " busy"}, 64'(busy_ok), 64'(1));
    check({tag, " hold"}, 64'(hold_ok), 64'(1));
    check({tag, " OUT"}, 64'(out), 64'(exp_out));
    check({tag, " Zero"}, 64'(zero), 64'(exp_zero));
    @(posedge clk); #1;
    check({tag, " pulse"}, 64'(done), 64'(0));
  endtask

  initial begin
    int seen;
    reset = 1'b1; start = 1'b0; op = OP_DIV; data_a = '0; data_b = '0;
    repeat (3) @(posedge clk);
    #1;
    check("rst OUT", 64'(out), 64'(0));
    check("rst Zero", 64'(zero), 64'(0));
    check("rst busy", 64'(busy), 64'(0));
    check("rst done", 64'(done), 64'(0));
    @(negedge clk); reset = 1'b0;

    run_op("divu 100/7", OP_DIVU, 32'd100, 32'd7, 32, 32'd14, 1'b0, 1'b0);
    run_op("remu 100/7", OP_REMU, 32'd100, 32'd7, 32, 32'd2, 1'b0, 1'b0);
    run_op("div -7/2",   OP_DIV, 32'hFFFF_FFF9, 32'd2, 32, 32'hFFFF_FFFD, 1'b0, 1'b0);
    run_op("rem -7/2",   OP_REM, 32'hFFFF_FFF9, 32'd2, 32, 32'hFFFF_FFFF, 1'b0, 1'b0);
    run_op("div 7/-2",   OP_DIV, 32'd7, 32'hFFFF_FFFE, 32, 32'hFFFF_FFFD, 1'b0, 1'b0);
    run_op("rem 7/-2",   OP_REM, 32'd7, 32'hFFFF_FFFE, 32, 32'd1, 1'b0, 1'b0);
    run_op("divu 0/5",   OP_DIVU, 32'd0, 32'd5, 32, 32'd0, 1'b1, 1'b0);
    run_op("divu max/1", OP_DIVU, 32'hFFFF_FFFF, 32'd1, 32, 32'hFFFF_FFFF, 1'b0, 1'b0);
    run_op("divu x/0",   OP_DIVU, 32'h1234, 32'd0, SPECIAL_LAT, 32'hFFFF_FFFF, 1'b0, 1'b0);
    run_op("remu x/0",   OP_REMU, 32'h1234, 32'd0, SPECIAL_LAT, 32'h1234, 1'b0, 1'b0);
    run_op("div -7/0",   OP_DIV, 32'hFFFF_FFF9, 32'd0, SPECIAL_LAT, 32'hFFFF_FFFF, 1'b0, 1'b0);
    run_op("rem -7/0",   OP_REM, 32'hFFFF_FFF9, 32'd0, SPECIAL_LAT, 32'hFFFF_FFF9, 1'b0, 1'b0);
    run_op("div ovf",    OP_DIV, 32'h8000_0000, 32'hFFFF_FFFF, SPECIAL_LAT, 32'h8000_0000, 1'b0, 1'b0);
    run_op("rem ovf",    OP_REM, 32'h8000_0000, 32'hFFFF_FFFF, SPECIAL_LAT, 32'd0, 1'b1, 1'b0);
    run_op("start in calc", OP_DIV, 32'd100, 32'd7, 32, 32'd14, 1'b0, 1'b1);

    // Reset 10 cycles into CALC aborts; OUT holds 14 beforehand so OUT=0 is meaningful.
    @(negedge clk);
    start = 1'b1; op = OP_DIVU; data_a = 32'd1000; data_b = 32'd3;
    @(posedge clk); #1;
    start = 1'b0;
    repeat (10) @(posedge clk);
    @(negedge clk); reset = 1'b1;
    @(posedge clk); #1;
    check("abort busy", 64'(busy), 64'(0));
    check("abort done", 64'(done), 64'(0));
    check("abort OUT", 64'(out), 64'(0));
    check("abort Zero", 64'(zero), 64'(0));
    @(negedge clk); reset = 1'b0;
    seen = 0;
    repeat (40) begin
      @(posedge clk); #1;
      if (done === 1'b1) seen++;
    end
    check("abort no done", 64'(seen), 64'(0));

    // Back-to-back operation after the abort still works.
    run_op("after abort", OP_REMU, 32'd1000, 32'd3, 32, 32'd1, 1'b0, 1'b0);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

  // Global time bound so the run always terminates.
  initial begin
    #200000;
    $display("FAIL timeout: simulation did not finish");
    $fatal(1, "timeout");
  end

endmodule
